i2c_access_arbiter: RTL and testbench
=====================================

Name: i2c_access_arbiter

Overview:
Shares the single memory-mapped I2C configurable master between two requesters: port 0 (processor core) and port 1 (auxiliary/DMA sequencer). Accepts one register access at a time and drives it onto the I2C block's address/write-data/write-enable interface. For writes that start a bus transfer, it holds the grant until the I2C block finishes or a timeout fires, so the other requester cannot disturb an in-flight transaction. Sits between the address decoder's I2C output and the I2C configurable block.

Parameters:
CTRL_ADDR, 32'h0000_0104, I2C register address whose write launches a bus transfer
BUSY_START_CYCLES, 4, maximum cycles to wait for i2c_busy to rise after a launch write
TIMEOUT_CYCLES, 1024, maximum cycles i2c_busy may stay high before the transfer is aborted
CNT_W, 11, counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  port 0 request
req0_we  in  1  port 0 write (1) / read (0)
req0_addr  in  32  port 0 register address
req0_wdata  in  32  port 0 write data
req0_ready  out  1  port 0 request accepted this cycle
req0_rvalid  out  1  port 0 response valid, one-cycle pulse
req0_rdata  out  32  port 0 read data, valid with req0_rvalid
req0_err  out  1  port 0 timeout error, valid with req0_rvalid
req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, req1_rvalid, req1_rdata, req1_err: same as port 0, for port 1
i2c_addr  out  32  address to the I2C block
i2c_wdata  out  32  write data to the I2C block
i2c_we  out  1  write strobe, one-cycle pulse
i2c_rdata  in  32  I2C block read data, combinational from i2c_addr
i2c_busy  in  1  I2C block transfer in progress

Behaviour:
- Reset (async): state IDLE; all outputs 0; last_grant=1, so port 0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP.
- IDLE: if exactly one reqN_valid, grant it. If both are valid, grant the port not equal to last_grant (round-robin). In the grant cycle: reqN_ready=1; latch we/addr/wdata and the grant id; update last_grant; go to ISSUE. At most one ready per cycle. ready is never 1 outside IDLE.
- ISSUE (1 cycle): drive i2c_addr/i2c_wdata from the latches.
  - On a write: i2c_we=1. If addr==CTRL_ADDR, go to WAIT_START. Otherwise go to RESP.
  - On a read: capture i2c_rdata into the response register and go to RESP.
- WAIT_START: if i2c_busy=1, go to WAIT_DONE and clear the counter. If BUSY_START_CYCLES elapse with busy low, go to RESP with err=0 (the launch was ignored by the I2C block).
- WAIT_DONE: if i2c_busy=0, go to RESP with err=0. If the counter reaches TIMEOUT_CYCLES, go to RESP with err=1. The counter saturates and does not wrap.
- RESP (1 cycle): pulse reqN_rvalid for the granted port, with rdata (0 for writes) and err. Next state is IDLE. A new grant is possible one cycle later.
- i2c_addr and i2c_wdata hold their latched values from ISSUE through RESP. They are 0 in IDLE.
- Latency:
  - read or non-launch write: grant -> rvalid = 2 cycles.
  - launch write: 2 + wait cycles.
- Any request arriving while not IDLE waits. The requester must hold valid/we/addr/wdata stable until ready.
- A request valid in the same cycle as a RESP is granted in the following IDLE cycle.
- reset asserted mid-transaction: return to IDLE immediately. No rvalid is issued and the pending request is dropped. The I2C block resets on the same reset.
- i2c_busy rising outside WAIT_START/WAIT_DONE is ignored.

Test Plan:
- Port 0 read, addr 0x100, i2c_rdata=0xA5 -> req0_ready at cycle T; i2c_addr=0x100 at T+1; req0_rvalid=1, req0_rdata=0xA5, err=0 at T+2.
- Port 1 write, addr 0x108, data 0x3C -> single i2c_we pulse with i2c_wdata=0x3C at T+1; req1_rvalid at T+2; no busy wait.
- Both valid in the same cycle for 4 consecutive requests after reset -> grants in order 0,1,0,1; never two readys in one cycle.
- Port 0 launch write to 0x104; busy rises 2 cycles after the we pulse and stays high 50 cycles; port 1 requests meanwhile -> port 1 ready is held 0 until port 0's rvalid; port 0 err=0.
- Launch write with busy stuck high, TIMEOUT_CYCLES=16 -> rvalid with err=1 exactly 16 cycles after entering WAIT_DONE; next request is served normally. Launch write with busy never rising -> rvalid, err=0, BUSY_START_CYCLES after ISSUE.
- Reset pulsed during WAIT_DONE -> all outputs 0 asynchronously; no rvalid; next port 0 request is granted first.

Source files
------------

// File: rtl/i2c_access_arbiter.sv
// Two-port arbiter in front of the memory-mapped I2C master: round-robin grant,
// one access at a time, grant held across a launched bus transfer until done or timeout.
module i2c_access_arbiter #(
  parameter logic [31:0] CTRL_ADDR         = 32'h0000_0104,
  parameter int          BUSY_START_CYCLES = 4,
  parameter int          TIMEOUT_CYCLES    = 1024,
  parameter int          CNT_W             = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        req0_rvalid,
  output logic [31:0] req0_rdata,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        req1_rvalid,
  output logic [31:0] req1_rdata,
  output logic        req1_err,
  output logic [31:0] i2c_addr,
  output logic [31:0] i2c_wdata,
  output logic        i2c_we,
  input  logic [31:0] i2c_rdata,
  input  logic        i2c_busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP} state_t;

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(BUSY_START_CYCLES - 1);
  localparam logic [CNT_W-1:0] DONE_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_nx;
  logic              grant_id, grant_nx;
  logic              last_grant, last_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              pick;

  logic              lat_we, we_nx;
  logic [31:0]       lat_addr, addr_nx;
  logic [31:0]       lat_wdata, wdata_nx;
  logic [31:0]       resp_rdata, rdata_nx;
  logic              resp_err, err_nx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state      <= state_nx;
      grant_id   <= grant_nx;
      last_grant <= last_nx;
      cnt        <= cnt_nx;
    end
  end

  // Latched request and response payload; only observed while not IDLE.
  always_ff @(posedge clk) begin
    lat_we     <= we_nx;
    lat_addr   <= addr_nx;
    lat_wdata  <= wdata_nx;
    resp_rdata <= rdata_nx;
    resp_err   <= err_nx;
  end

  always_comb begin
    state_nx   = state;
    grant_nx   = grant_id;
    last_nx    = last_grant;
    cnt_nx     = cnt;
    we_nx      = lat_we;
    addr_nx    = lat_addr;
    wdata_nx   = lat_wdata;
    rdata_nx   = resp_rdata;
    err_nx     = resp_err;
    pick       = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    i2c_we     = 1'b0;
    case (state)
      IDLE: begin
        if (!reset && (req0_valid || req1_valid)) begin
          // On a tie the port that did not win last time is served.
          pick       = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
          req0_ready = ~pick;
          req1_ready = pick;
          grant_nx   = pick;
          last_nx    = pick;
          we_nx      = pick ? req1_we    : req0_we;
          addr_nx    = pick ? req1_addr  : req0_addr;
          wdata_nx   = pick ? req1_wdata : req0_wdata;
          rdata_nx   = '0;
          err_nx     = 1'b0;
          cnt_nx     = '0;
          state_nx   = ISSUE;
        end
      end
      ISSUE: begin
        i2c_we = lat_we;
        if (lat_we) begin
          state_nx = (lat_addr == CTRL_ADDR) ? WAIT_START : RESP;
        end else begin
          rdata_nx = i2c_rdata;
          state_nx = RESP;
        end
      end
      WAIT_START: begin
        if (i2c_busy) begin
          cnt_nx   = '0;
          state_nx = WAIT_DONE;
        end else if (cnt >= START_LAST) begin
          state_nx = RESP;
        end else begin
          cnt_nx = sat_inc(cnt);
        end
      end
      WAIT_DONE: begin
        if (!i2c_busy) begin
          state_nx = RESP;
        end else if (cnt >= DONE_LAST) begin
          err_nx   = 1'b1;
          state_nx = RESP;
        end else begin
          cnt_nx = sat_inc(cnt);
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign i2c_addr    = (state == IDLE) ? '0 : lat_addr;
  assign i2c_wdata   = (state == IDLE) ? '0 : lat_wdata;
  assign req0_rvalid = (state == RESP) && !grant_id;
  assign req1_rvalid = (state == RESP) && grant_id;
  assign req0_rdata  = req0_rvalid ? resp_rdata : '0;
  assign req1_rdata  = req1_rvalid ? resp_rdata : '0;
  assign req0_err    = req0_rvalid & resp_err;
  assign req1_err    = req1_rvalid & resp_err;

endmodule

// File: tb/tb_i2c_access_arbiter.sv
// Directed bench for i2c_access_arbiter; a second instance with a short timeout
// covers the busy-stuck abort path.
module tb_i2c_access_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        req0_ready, req0_rvalid, req0_err, req1_ready, req1_rvalid, req1_err;
  logic [31:0] req0_rdata, req1_rdata;
  logic [31:0] i2c_addr, i2c_wdata, i2c_rdata;
  logic        i2c_we, i2c_busy;

  logic        t_req0_valid, t_req0_we, t_req1_valid, t_req1_we;
  logic [31:0] t_req0_addr, t_req0_wdata, t_req1_addr, t_req1_wdata;
  logic        t_req0_ready, t_req0_rvalid, t_req0_err, t_req1_ready, t_req1_rvalid, t_req1_err;
  logic [31:0] t_req0_rdata, t_req1_rdata;
  logic [31:0] t_i2c_addr, t_i2c_wdata, t_i2c_rdata;
  logic        t_i2c_we, t_i2c_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // I2C register file stand-in: combinational read data keyed on address.
  assign i2c_rdata   = (i2c_addr == 32'h100) ? 32'hA5 : 32'hDEAD_BEEF;
  assign t_i2c_rdata = (t_i2c_addr == 32'h100) ? 32'hA5 : 32'hDEAD_BEEF;

  i2c_access_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata), .i2c_we(i2c_we),
    .i2c_rdata(i2c_rdata), .i2c_busy(i2c_busy)
  );

  i2c_access_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut_t (
    .clk(clk), .reset(reset),
    .req0_valid(t_req0_valid), .req0_we(t_req0_we), .req0_addr(t_req0_addr), .req0_wdata(t_req0_wdata),
    .req0_ready(t_req0_ready), .req0_rvalid(t_req0_rvalid), .req0_rdata(t_req0_rdata), .req0_err(t_req0_err),
    .req1_valid(t_req1_valid), .req1_we(t_req1_we), .req1_addr(t_req1_addr), .req1_wdata(t_req1_wdata),
    .req1_ready(t_req1_ready), .req1_rvalid(t_req1_rvalid), .req1_rdata(t_req1_rdata), .req1_err(t_req1_err),
    .i2c_addr(t_i2c_addr), .i2c_wdata(t_i2c_wdata), .i2c_we(t_i2c_we),
    .i2c_rdata(t_i2c_rdata), .i2c_busy(t_i2c_busy)
  );

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    next(); next();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h100; req0_wdata = '0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h100; req1_wdata = '0;
    i2c_busy = 1'b0;
    t_req0_valid = 1'b0; t_req0_we = 1'b0; t_req0_addr = '0; t_req0_wdata = '0;
    t_req1_valid = 1'b0; t_req1_we = 1'b0; t_req1_addr = '0; t_req1_wdata = '0;
    t_i2c_busy = 1'b0;
    next(); mid();
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b%b want 00", req0_ready, req1_ready); end
    checks++; if (i2c_addr !== 32'h0 || i2c_wdata !== 32'h0 || i2c_we !== 1'b0) begin errors++; $display("FAIL rst_i2c: got addr %h wdata %h we %b want 0", i2c_addr, i2c_wdata, i2c_we); end
    checks++; if ({req0_rvalid, req1_rvalid, req0_err, req1_err} !== 4'b0 || req0_rdata !== 32'h0 || req1_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp: got rvalid %b%b rdata %h %h want 0", req0_rvalid, req1_rvalid, req0_rdata, req1_rdata); end
    next();
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    next();
  endtask

  task automatic test_read_p0();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h100;
    mid();
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rd_ready: got %b%b want 10", req0_ready, req1_ready); end
    next(); req0_valid = 1'b0; mid();
    checks++; if (i2c_addr !== 32'h100 || i2c_we !== 1'b0 || req0_rvalid !== 1'b0) begin errors++; $display("FAIL rd_issue: got addr %h we %b rvalid %b want 100 0 0", i2c_addr, i2c_we, req0_rvalid); end
    next(); mid();
    checks++; if (req0_rvalid !== 1'b1 || req0_rdata !== 32'hA5 || req0_err !== 1'b0) begin errors++; $display("FAIL rd_resp: got rvalid %b rdata %h err %b want 1 a5 0", req0_rvalid, req0_rdata, req0_err); end
    checks++; if (i2c_addr !== 32'h100 || req1_rvalid !== 1'b0) begin errors++; $display("FAIL rd_hold: got addr %h rvalid1 %b want 100 0", i2c_addr, req1_rvalid); end
    next(); mid();
    checks++; if (i2c_addr !== 32'h0 || req0_rvalid !== 1'b0) begin errors++; $display("FAIL rd_idle: got addr %h rvalid %b want 0 0", i2c_addr, req0_rvalid); end
    next();
  endtask

  task automatic test_write_p1();
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h108; req1_wdata = 32'h3C;
    mid();
    checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL wr_ready: got %b%b want 01", req0_ready, req1_ready); end
    next(); req1_valid = 1'b0; mid();
    checks++; if (i2c_we !== 1'b1 || i2c_wdata !== 32'h3C || i2c_addr !== 32'h108) begin errors++; $display("FAIL wr_issue: got we %b wdata %h addr %h want 1 3c 108", i2c_we, i2c_wdata, i2c_addr); end
    next(); mid();
    checks++; if (i2c_we !== 1'b0 || req1_rvalid !== 1'b1 || req1_rdata !== 32'h0 || req1_err !== 1'b0) begin errors++; $display("FAIL wr_resp: got we %b rvalid %b rdata %h err %b want 0 1 0 0", i2c_we, req1_rvalid, req1_rdata, req1_err); end
    next(); mid();
    checks++; if (req1_rvalid !== 1'b0 || i2c_we !== 1'b0) begin errors++; $display("FAIL wr_after: got rvalid %b we %b want 0 0", req1_rvalid, i2c_we); end
    next();
  endtask

  task automatic test_round_robin();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h100;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      logic exp1;
      exp1 = k[0];
      mid();
      checks++; if (req0_ready !== ~exp1 || req1_ready !== exp1) begin errors++; $display("FAIL rr_grant%0d: got %b%b want %b%b", k, req0_ready, req1_ready, ~exp1, exp1); end
      next();
      if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      mid();
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL rr_issue%0d: got ready %b%b want 00", k, req0_ready, req1_ready); end
      next(); mid();
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || req0_rvalid !== ~exp1 || req1_rvalid !== exp1) begin errors++; $display("FAIL rr_resp%0d: got ready %b%b rvalid %b%b", k, req0_ready, req1_ready, req0_rvalid, req1_rvalid); end
      checks++; if ((exp1 ? req1_rdata : req0_rdata) !== (exp1 ? 32'hDEAD_BEEF : 32'hA5)) begin errors++; $display("FAIL rr_rdata%0d: got %h %h", k, req0_rdata, req1_rdata); end
      next();
    end
  endtask

  task automatic test_launch_hold();
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h104; req0_wdata = 32'h1;
    mid();
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL lh_ready: got %b want 1", req0_ready); end
    next();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h100;
    mid();
    checks++; if (i2c_we !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL lh_issue: got we %b ready1 %b want 1 0", i2c_we, req1_ready); end
    next(); mid();
    checks++; if (req1_ready !== 1'b0 || i2c_we !== 1'b0) begin errors++; $display("FAIL lh_ws: got ready1 %b we %b want 0 0", req1_ready, i2c_we); end
    next(); i2c_busy = 1'b1;
    for (int j = 2; j <= 51; j++) begin
      mid();
      checks++; if (req1_ready !== 1'b0 || req0_rvalid !== 1'b0) begin errors++; $display("FAIL lh_busy%0d: got ready1 %b rvalid0 %b want 0 0", j, req1_ready, req0_rvalid); end
      next();
    end
    i2c_busy = 1'b0;
    mid();
    checks++; if (req1_ready !== 1'b0 || req0_rvalid !== 1'b0) begin errors++; $display("FAIL lh_drop: got ready1 %b rvalid0 %b want 0 0", req1_ready, req0_rvalid); end
    next(); mid();
    checks++; if (req0_rvalid !== 1'b1 || req0_err !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL lh_resp: got rvalid %b err %b ready1 %b want 1 0 0", req0_rvalid, req0_err, req1_ready); end
    next(); mid();
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL lh_p1grant: got %b want 1", req1_ready); end
    next(); req1_valid = 1'b0;
    next(); mid();
    checks++; if (req1_rvalid !== 1'b1 || req1_rdata !== 32'hA5) begin errors++; $display("FAIL lh_p1resp: got rvalid %b rdata %h want 1 a5", req1_rvalid, req1_rdata); end
    next();
  endtask

  task automatic test_no_busy();
    i2c_busy = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h104; req0_wdata = 32'h2;
    mid();
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL nb_ready: got %b want 1", req0_ready); end
    next(); req0_valid = 1'b0; mid();
    checks++; if (i2c_we !== 1'b1 || i2c_wdata !== 32'h2) begin errors++; $display("FAIL nb_issue: got we %b wdata %h want 1 2", i2c_we, i2c_wdata); end
    for (int j = 1; j <= 4; j++) begin
      next(); mid();
      checks++; if (req0_rvalid !== 1'b0 || i2c_addr !== 32'h104) begin errors++; $display("FAIL nb_wait%0d: got rvalid %b addr %h want 0 104", j, req0_rvalid, i2c_addr); end
    end
    next(); mid();
    checks++; if (req0_rvalid !== 1'b1 || req0_err !== 1'b0 || req0_rdata !== 32'h0) begin errors++; $display("FAIL nb_resp: got rvalid %b err %b rdata %h want 1 0 0", req0_rvalid, req0_err, req0_rdata); end
    next();
  endtask

  task automatic test_timeout();
    t_req0_valid = 1'b1; t_req0_we = 1'b1; t_req0_addr = 32'h104; t_req0_wdata = 32'h7;
    mid();
    checks++; if (t_req0_ready !== 1'b1) begin errors++; $display("FAIL to_ready: got %b want 1", t_req0_ready); end
    next(); t_req0_valid = 1'b0; t_i2c_busy = 1'b1; mid();
    checks++; if (t_i2c_we !== 1'b1) begin errors++; $display("FAIL to_issue: got we %b want 1", t_i2c_we); end
    next(); mid();
    checks++; if (t_req0_rvalid !== 1'b0) begin errors++; $display("FAIL to_ws: got rvalid %b want 0", t_req0_rvalid); end
    for (int j = 0; j < 16; j++) begin
      next(); mid();
      checks++; if (t_req0_rvalid !== 1'b0) begin errors++; $display("FAIL to_wait%0d: got rvalid %b want 0", j, t_req0_rvalid); end
    end
    next(); mid();
    checks++; if (t_req0_rvalid !== 1'b1 || t_req0_err !== 1'b1) begin errors++; $display("FAIL to_resp: got rvalid %b err %b want 1 1", t_req0_rvalid, t_req0_err); end
    next(); t_i2c_busy = 1'b0;
    t_req1_valid = 1'b1; t_req1_we = 1'b0; t_req1_addr = 32'h100;
    mid();
    checks++; if (t_req1_ready !== 1'b1) begin errors++; $display("FAIL to_next_ready: got %b want 1", t_req1_ready); end
    next(); t_req1_valid = 1'b0;
    next(); mid();
    checks++; if (t_req1_rvalid !== 1'b1 || t_req1_err !== 1'b0 || t_req1_rdata !== 32'hA5) begin errors++; $display("FAIL to_next_resp: got rvalid %b err %b rdata %h want 1 0 a5", t_req1_rvalid, t_req1_err, t_req1_rdata); end
    next();
  endtask

  task automatic test_reset_mid();
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h104; req0_wdata = 32'h9;
    mid();
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b want 1", req0_ready); end
    next(); req0_valid = 1'b0; i2c_busy = 1'b1;
    next(); next(); mid();
    checks++; if (i2c_addr !== 32'h104 || i2c_wdata !== 32'h9) begin errors++; $display("FAIL rm_inflight: got addr %h wdata %h want 104 9", i2c_addr, i2c_wdata); end
    #2 reset = 1'b1;
    #1;
    checks++; if (i2c_addr !== 32'h0 || i2c_wdata !== 32'h0 || i2c_we !== 1'b0 || req0_rvalid !== 1'b0) begin errors++; $display("FAIL rm_async: got addr %h wdata %h we %b rvalid %b want 0", i2c_addr, i2c_wdata, i2c_we, req0_rvalid); end
    i2c_busy = 1'b0;
    for (int j = 0; j < 2; j++) begin
      next(); mid();
      checks++; if (req0_rvalid !== 1'b0 || req1_rvalid !== 1'b0) begin errors++; $display("FAIL rm_norvalid%0d: got %b%b want 00", j, req0_rvalid, req1_rvalid); end
    end
    next();
    reset = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h100;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h200;
    mid();
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rm_first: got %b%b want 10", req0_ready, req1_ready); end
    next(); req0_valid = 1'b0; req1_valid = 1'b0;
    next(); mid();
    checks++; if (req0_rvalid !== 1'b1 || req0_rdata !== 32'hA5) begin errors++; $display("FAIL rm_resp: got rvalid %b rdata %h want 1 a5", req0_rvalid, req0_rdata); end
    next(); next();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_p0();
    test_write_p1();
    do_reset();
    test_round_robin();
    test_launch_hold();
    test_no_busy();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
